mem_sram_ctrl: RTL and testbench

- Multi-cycle data-memory controller that sits directly downstream of the MEM stage. It replaces the single-cycle data memory behind the MEM stage, which drives its read/write enables, ALU result (as address) and Val_Rm (as store data) into this block.
- It serialises each 32-bit access into two 16-bit external SRAM accesses.
- While an access is in progress it holds ready low. The CPU uses ready to freeze the whole pipeline.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_wait_counter.sv | 47 ++++
 rtl/mem_sram_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the multi-cycle SRAM data-memory controller:
// access FSM states, default address map base, half-word width and
// the wait-counter width helper.
package mem_ctrl_pkg;

    localparam int unsigned HALF_W            = 16;
    localparam int unsigned BASE_ADDR_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

    // Counter width able to hold 0..cycles-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 32'd1) ? 32'($clog2(cycles)) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Clear/enable up-counter with a registered terminal-count flag.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear (wins over en_i)
//   en_i        count enable
//   cnt_o       current count
//   tc_o        high while cnt_o == TERM
module mem_wait_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned TERM  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;

    // Next count; the flag is derived from it so tc_o is a plain register.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
        tc_d = (32'(cnt_d) == TERM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= (TERM == 32'd0);
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: rtl/mem_sram_ctrl.sv
// Multi-cycle data-memory controller behind the MEM stage. Each 32-bit
// load/store is split into two 16-bit SRAM accesses (low half, then high
// half), each held on the bus for WAIT_CYCLES cycles. ready stalls the
// pipeline while an access is in flight.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_en, wr_en        load/store request levels (both high = store)
//   address, write_data byte address and store data from the MEM stage
//   read_data           registered load result
//   ready               combinational; low = freeze pipeline
//   sram_addr           half-word address to SRAM
//   sram_dq_out/_in     SRAM write/read data
//   sram_dq_oe          1 = controller drives DQ
//   sram_we_n           active-low SRAM write strobe
module mem_sram_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [HALF_W-1:0]      sram_dq_out,
    input  logic [HALF_W-1:0]      sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int unsigned CNT_W    = cnt_width(WAIT_CYCLES);
    localparam int unsigned IDX_W    = SRAM_ADDR_W - 1;
    localparam int unsigned LAST_CNT = WAIT_CYCLES - 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt;
    logic                    cnt_tc;
    logic                    cnt_clr;
    logic [HALF_W-1:0]       low_q, low_d;
    logic [31:0]             read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [HALF_W-1:0]       dq_out_q, dq_out_d;
    logic                    oe_q, oe_d;
    logic                    we_n_q, we_n_d;
    logic                    req;
    logic                    active_d;
    logic                    last_d;
    logic [31:0]             byte_off;
    logic [IDX_W-1:0]        idx;
    logic                    unused_off;

    // Word index relative to BASE_ADDR; bits above the SRAM range wrap.
    assign byte_off   = address - 32'(BASE_ADDR);
    assign idx        = byte_off[IDX_W+1:2];
    assign unused_off = ^{byte_off[31:IDX_W+2], byte_off[1:0]};

    assign req   = rd_en | wr_en;
    assign ready = ~req | (state_q == ST_DONE);

    mem_wait_counter #(
        .WIDTH (CNT_W),
        .TERM  (LAST_CNT)
    ) u_wait (
        .clk   (clk),
        .rst_n (rst),
        .clr_i (cnt_clr),
        .en_i  (1'b1),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // Next state, read capture and next values of the registered SRAM pins.
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b1;
        low_d       = low_q;
        read_data_d = read_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (cnt_tc) begin
                    state_d = ST_HIGH;
                    if (!wr_en) low_d = sram_dq_in;
                end else begin
                    cnt_clr = 1'b0;
                end
            end
            ST_HIGH: begin
                if (cnt_tc) begin
                    state_d = ST_DONE;
                    if (!wr_en) read_data_d = {sram_dq_in, low_q};
                end else begin
                    cnt_clr = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins are registered, so they follow the state/count of the next cycle.
        active_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
        last_d   = active_d &&
                   ((cnt_clr ? 32'd0 : 32'(cnt) + 32'd1) == LAST_CNT);

        oe_d        = active_d & wr_en;
        we_n_d      = ~(oe_d & ~last_d);
        sram_addr_d = active_d ? {idx, (state_d == ST_HIGH)} : '0;
        dq_out_d    = '0;
        if (oe_d) begin
            dq_out_d = (state_d == ST_HIGH) ? write_data[2*HALF_W-1:HALF_W]
                                            : write_data[HALF_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            low_q       <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            low_q       <= low_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
        end
    end

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: a behavioural half-word SRAM plus a word-level
// reference memory; each scenario task drives requests and checks latency,
// write strobes, SRAM contents and load results.
module tb_mem_sram_ctrl;

    localparam int unsigned W    = 5;
    localparam int unsigned BASE = 1024;
    localparam int unsigned AW   = 18;
    localparam int          LAT  = 2 * int'(W) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic [15:0]   sram_dq_in;
    logic          sram_dq_oe;
    logic          sram_we_n;

    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [15:0]   pre_val;

    bit   [15:0]   sram [0:(1<<AW)-1];
    logic [31:0]   ref_mem [int];
    logic [31:0]   exp_rd;
    int            total = 0;
    int            bad   = 0;

    mem_sram_ctrl #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE),
        .SRAM_ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    // Half-word SRAM: bench preload port, otherwise written while we_n is low.
    always @(posedge clk) begin
        if (pre_en) sram[pre_addr] <= pre_val;
        else if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = sram[sram_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ref_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & 32'((1 << (AW - 1)) - 1));
    endfunction

    function automatic logic [31:0] ref_read(input int i);
        return ref_mem.exists(i) ? ref_mem[i] : 32'h0;
    endfunction

    // we_n per cycle k of an access (k=0 request cycle, k=2W+1 done cycle).
    function automatic logic [31:0] exp_wtr(input bit w);
        logic [31:0] m;
        m = '1;
        if (w) begin
            for (int k = 1; k <= 2 * int'(W); k++)
                if (k != int'(W) && k != 2 * int'(W)) m[k] = 1'b0;
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) tick();
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        int i;
        i = ref_idx(a);
        pre_en   = 1'b1;
        pre_addr = AW'(2 * i);
        pre_val  = v[15:0];
        tick();
        pre_addr = AW'(2 * i + 1);
        pre_val  = v[31:16];
        tick();
        pre_en = 1'b0;
        ref_mem[i] = v;
    endtask

    // Drive one request and wait (bounded) for ready; ends in the done cycle.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] wtr, output bit chg);
        logic [31:0] rd0;
        rd0        = read_data;
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        #1;
        lat = 0;
        wtr = '1;
        chg = 1'b0;
        while (ready !== 1'b1 && lat < 100) begin
            if (lat < 32) wtr[lat] = sram_we_n;
            if (read_data !== rd0) chg = 1'b1;
            lat++;
            tick();
        end
        if (lat < 32) wtr[lat] = sram_we_n;
        if (read_data !== rd0) chg = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        address = '0; write_data = '0; pre_en = 1'b0; pre_addr = '0; pre_val = '0;
        repeat (2) tick();
        rst = 1'b1;
        exp_rd = 32'h0;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if ({ready, sram_we_n, sram_dq_oe, read_data, sram_addr} !==
                {3'b110, 32'h0, {AW{1'b0}}}) begin
                bad++;
                $display("FAIL reset_idle c=%0d: rdy=%b we_n=%b oe=%b rd=%h addr=%h, need 1 1 0 0 0",
                         c, ready, sram_we_n, sram_dq_oe, read_data, sram_addr);
            end
        end
    endtask

    task automatic test_write();
        int lat; logic [31:0] wtr; logic [31:0] em; bit chg;
        em = exp_wtr(1'b1);
        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lat, wtr, chg);
        ref_mem[ref_idx(32'd1028)] = 32'hDEADBEEF;
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL write_latency: got %0d need %0d", lat, LAT); end
        total++;
        if (wtr !== em) begin bad++; $display("FAIL write_we_n: got %b need %b", wtr, em); end
        total++;
        if (chg) begin bad++; $display("FAIL write_rd_stable: read_data changed, now %h", read_data); end
        idle(1);
        total++;
        if (sram[2] !== 16'hBEEF || sram[3] !== 16'hDEAD) begin
            bad++;
            $display("FAIL write_sram: hw2=%h hw3=%h need BEEF DEAD", sram[2], sram[3]);
        end
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL write_idle_ready: got %b need 1", ready); end
    endtask

    task automatic test_read();
        int lat; logic [31:0] wtr; logic [31:0] em; bit chg;
        em = exp_wtr(1'b0);
        access(1'b0, 1'b1, 32'd1028, 32'h0, lat, wtr, chg);
        exp_rd = ref_read(ref_idx(32'd1028));
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL read_latency: got %0d need %0d", lat, LAT); end
        total++;
        if (read_data !== exp_rd) begin bad++; $display("FAIL read_data: got %h need %h", read_data, exp_rd); end
        total++;
        if (wtr !== em) begin bad++; $display("FAIL read_we_n: got %b need %b", wtr, em); end
        idle(3);
        total++;
        if (read_data !== exp_rd) begin bad++; $display("FAIL read_hold: got %h need %h", read_data, exp_rd); end
    endtask

    task automatic test_back_to_back();
        int cyc; int d1; int d2; logic [31:0] v1; logic [31:0] v2;
        preload(32'd1024, 32'h00010002);
        preload(32'd1032, 32'hCAFEF00D);
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
        #1;
        cyc = 0; d1 = -1; d2 = -1; v1 = '0; v2 = '0;
        while (cyc < 60 && d2 < 0) begin
            if (ready === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc; v1 = read_data; address = 32'd1032;
                end else begin
                    d2 = cyc; v2 = read_data;
                end
            end
            if (d2 < 0) begin tick(); cyc++; end
        end
        idle(1);
        total++;
        if (d1 !== LAT) begin bad++; $display("FAIL b2b_first_done: got %0d need %0d", d1, LAT); end
        total++;
        if (d2 - d1 !== LAT + 1) begin bad++; $display("FAIL b2b_spacing: got %0d need %0d", d2 - d1, LAT + 1); end
        total++;
        if (v1 !== ref_read(ref_idx(32'd1024))) begin bad++; $display("FAIL b2b_data1: got %h need %h", v1, ref_read(ref_idx(32'd1024))); end
        exp_rd = ref_read(ref_idx(32'd1032));
        total++;
        if (v2 !== exp_rd) begin bad++; $display("FAIL b2b_data2: got %h need %h", v2, exp_rd); end
    endtask

    task automatic test_rw_both();
        int lat; logic [31:0] wtr; logic [31:0] em; bit chg;
        em = exp_wtr(1'b1);
        access(1'b1, 1'b1, 32'd1036, 32'h12345678, lat, wtr, chg);
        ref_mem[ref_idx(32'd1036)] = 32'h12345678;
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL both_latency: got %0d need %0d", lat, LAT); end
        total++;
        if (chg || read_data !== exp_rd) begin bad++; $display("FAIL both_rd_stable: got %h need %h", read_data, exp_rd); end
        total++;
        if (wtr !== em) begin bad++; $display("FAIL both_we_n: got %b need %b", wtr, em); end
        idle(1);
        access(1'b0, 1'b1, 32'd1036, 32'h0, lat, wtr, chg);
        exp_rd = ref_read(ref_idx(32'd1036));
        total++;
        if (read_data !== 32'h12345678) begin bad++; $display("FAIL both_readback: got %h need 12345678", read_data); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] wtr; logic [31:0] em; bit chg;
        em = exp_wtr(1'b1);
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'hA5A55A5A;
        #1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        exp_rd = 32'h0;
        total++;
        if ({sram_we_n, sram_dq_oe, sram_addr, read_data} !== {2'b10, {AW{1'b0}}, 32'h0}) begin
            bad++;
            $display("FAIL midrst_pins: we_n=%b oe=%b addr=%h rd=%h need 1 0 0 0",
                     sram_we_n, sram_dq_oe, sram_addr, read_data);
        end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_req: got %b need 0", ready); end
        wr_en = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_noreq: got %b need 1", ready); end
        #2;
        rst = 1'b1;
        tick();
        total++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            bad++;
            $display("FAIL midrst_release: rdy=%b we_n=%b need 1 1", ready, sram_we_n);
        end
        access(1'b1, 1'b0, 32'd1040, 32'h0BADCAFE, lat, wtr, chg);
        ref_mem[ref_idx(32'd1040)] = 32'h0BADCAFE;
        total++;
        if (lat !== LAT || wtr !== em) begin
            bad++;
            $display("FAIL midrst_rewrite: lat=%0d we_n=%b need %0d %b", lat, wtr, LAT, em);
        end
        idle(1);
        access(1'b0, 1'b1, 32'd1040, 32'h0, lat, wtr, chg);
        exp_rd = ref_read(ref_idx(32'd1040));
        total++;
        if (read_data !== exp_rd) begin bad++; $display("FAIL midrst_readback: got %h need %h", read_data, exp_rd); end
        idle(1);
    endtask

    task automatic test_random();
        int lat; logic [31:0] wtr; bit chg;
        int op; int k; logic [31:0] a; logic [31:0] d; int i;
        for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 2));
            k  = int'($urandom_range(0, 9));
            if (k == 0)      a = BASE - 32'd4;
            else if (k == 1) a = BASE + 32'(1 << 19) + 32'(4 * $urandom_range(0, 3));
            else             a = BASE + 32'(4 * $urandom_range(0, 7));
            a = a + 32'($urandom_range(0, 3));
            d = $urandom;
            i = ref_idx(a);
            access(op != 0, op != 1, a, d, lat, wtr, chg);
            total++;
            if (lat !== LAT) begin bad++; $display("FAIL rand_latency n=%0d: got %0d need %0d", n, lat, LAT); end
            if (op != 0) begin
                ref_mem[i] = d;
                total++;
                if (chg || read_data !== exp_rd) begin
                    bad++;
                    $display("FAIL rand_write_rd n=%0d: got %h need %h", n, read_data, exp_rd);
                end
            end else begin
                exp_rd = ref_read(i);
                total++;
                if (read_data !== exp_rd) begin
                    bad++;
                    $display("FAIL rand_read n=%0d addr=%h: got %h need %h", n, a, read_data, exp_rd);
                end
            end
            idle(int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_rw_both();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
